// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the core and the MULTU/DIVU sequencer.
//   start, op, src_a, src_b : request (core -> unit)
//   busy, done, div_by_zero : status (unit -> core)
//   hi, lo                  : MIPS HI/LO results (unit -> core)
interface muldiv_if #(parameter int WIDTH = 32);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (output start, op, src_a, src_b, input busy, done, div_by_zero, hi, lo);
    modport slave (input start, op, src_a, src_b, output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle unsigned MULTU/DIVU using one external ALU pass per iteration.
//   clk, reset_n       : rising-edge clock, asynchronous active-low reset
//   bus (slave)        : start/op/src_a/src_b request, busy/done/div_by_zero/hi/lo result
//   alu_operandA/B     : operands driven to the external ALU
//   alu_command        : ALU command (CMD_ADD / CMD_SUB)
//   alu_result         : combinational ALU result for this cycle
//   alu_carryout       : ALU carry; for SUB, 1 means no borrow
module muldiv_sequencer #(
    parameter int         WIDTH   = 32,
    parameter logic [2:0] CMD_ADD = 3'd0,
    parameter logic [2:0] CMD_SUB = 3'd1
) (
    input  logic             clk,
    input  logic             reset_n,
    muldiv_if.slave          bus,
    output logic [WIDTH-1:0] alu_operandA,
    output logic [WIDTH-1:0] alu_operandB,
    output logic [2:0]       alu_command,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryout
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] p, q, m, t, p_n, q_n, hi_r, lo_r;
    logic [CW-1:0]    cnt;
    logic             mode, dz, qbit, accept, zero_div, last;

    assign accept   = bus.start && state != RUN;
    assign zero_div = bus.op && bus.src_b == '0;
    assign last     = cnt == CW'(WIDTH - 1);

    assign bus.busy        = state == RUN;
    assign bus.done        = state == DONE;
    assign bus.div_by_zero = state == DONE && dz;
    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_n;

    always_comb begin
        state_n      = state == RUN ? (last ? DONE : RUN) : accept ? (zero_div ? DONE : RUN) : IDLE;
        // Divide trial value: remainder shifted left with the next dividend bit.
        t            = {p[WIDTH-2:0], q[WIDTH-1]};
        // P's MSB stands in for bit WIDTH of the trial value, which always fits the divisor.
        qbit         = p[WIDTH-1] | alu_carryout;
        alu_command  = (state == RUN && mode) ? CMD_SUB : CMD_ADD;
        alu_operandA = state != RUN ? '0 : mode ? t : p;
        alu_operandB = state != RUN ? '0 : (mode || q[0]) ? m : '0;
        p_n          = mode ? (qbit ? alu_result : t) : {alu_carryout, alu_result[WIDTH-1:1]};
        q_n          = mode ? {q[WIDTH-2:0], qbit} : {alu_result[0], q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            p    <= '0;
            q    <= '0;
            m    <= '0;
            cnt  <= '0;
            mode <= 1'b0;
            dz   <= 1'b0;
            hi_r <= '0;
            lo_r <= '0;
        end else if (accept && zero_div) begin
            hi_r <= bus.src_a;
            lo_r <= '1;
            dz   <= 1'b1;
        end else if (accept) begin
            p    <= '0;
            q    <= bus.op ? bus.src_a : bus.src_b;
            m    <= bus.op ? bus.src_b : bus.src_a;
            mode <= bus.op;
            cnt  <= '0;
            dz   <= 1'b0;
        end else if (state == RUN) begin
            p   <= p_n;
            q   <= q_n;
            cnt <= last ? '0 : cnt + 1'b1;
            if (last) begin
                hi_r <= p_n;
                lo_r <= q_n;
            end
        end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: random and directed MULTU/DIVU checks against an arithmetic reference model.
module tb_muldiv_sequencer;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] alu_a, alu_b, alu_res;
    logic [2:0]   alu_cmd;
    logic         alu_c;
    logic [W:0]   sum;

    int vectors = 0;
    int misses = 0;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus),
        .alu_operandA(alu_a),
        .alu_operandB(alu_b),
        .alu_command(alu_cmd),
        .alu_result(alu_res),
        .alu_carryout(alu_c)
    );

    always #5 clk = ~clk;

    // External combinational ALU: ADD=0, SUB=1 (carry=1 means no borrow).
    always_comb begin
        sum     = alu_cmd == 3'd1 ? {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1 : {1'b0, alu_a} + {1'b0, alu_b};
        alu_res = sum[W-1:0];
        alu_c   = sum[W];
    end

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        vectors++;
        if (act !== exp) begin
            misses++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: edge-numbered timeline, results from plain * / %.
    int           cyc = 0, done_edge = 0;
    logic         pend = 0, m_busy = 0, exp_done = 0, exp_dz = 0;
    logic [W-1:0] pend_hi = 0, pend_lo = 0, hold_hi = 0, hold_lo = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend     <= 0;
            m_busy   <= 0;
            exp_done <= 0;
            exp_dz   <= 0;
            hold_hi  <= 0;
            hold_lo  <= 0;
        end else begin : mdl
            int           e, de;
            logic         p, d, z;
            logic [W-1:0] hh, hl, ph, pl;
            logic [63:0]  r;
            e = cyc + 1; de = done_edge; p = pend; d = 0; z = 0;
            hh = hold_hi; hl = hold_lo; ph = pend_hi; pl = pend_lo;
            if (p && e == de) begin
                hh = ph; hl = pl; d = 1; p = 0;
            end
            if (bus.start && !m_busy) begin
                if (bus.op && bus.src_b == 0) begin
                    hh = bus.src_a; hl = '1; d = 1; z = 1;
                end else begin
                    r  = bus.op ? {bus.src_a % bus.src_b, bus.src_a / bus.src_b}
                                : 64'(bus.src_a) * 64'(bus.src_b);
                    ph = r[63:32]; pl = r[31:0]; p = 1; de = e + W;
                end
            end
            cyc       <= e;
            done_edge <= de;
            pend      <= p;
            pend_hi   <= ph;
            pend_lo   <= pl;
            hold_hi   <= hh;
            hold_lo   <= hl;
            exp_done  <= d;
            exp_dz    <= z;
            m_busy    <= p && e < de;
        end
    end

    always @(negedge clk) begin
        chk("busy", 80'(bus.busy), 80'(m_busy));
        chk("done", 80'(bus.done), 80'(exp_done));
        chk("hi", 80'(bus.hi), 80'(hold_hi));
        chk("lo", 80'(bus.lo), 80'(hold_lo));
        if (exp_done)
            chk("div_by_zero", 80'(bus.div_by_zero), 80'(exp_dz));
        if (!m_busy)
            chk("alu_idle", 80'({alu_cmd, alu_a, alu_b}), 80'(0));
    end

    // Issue one request from a negedge; returns at the negedge of the done cycle.
    // lat counts cycles after the start edge (1 = cycle right after it).
    task automatic run(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int poke, output int lat, output int nb);
        bus.op = o; bus.src_a = a; bus.src_b = b; bus.start = 1;
        @(posedge clk);
        #1 bus.start = 0;
        lat = 0;
        nb = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            nb += int'(bus.busy);
            if (bus.done) begin
                lat = k;
                break;
            end
            if (k == poke) begin
                bus.op = ~o; bus.src_a = $urandom; bus.src_b = $urandom; bus.start = 1;
                @(posedge clk);
                #1 bus.start = 0;
            end
        end
        if (lat == 0)
            chk("done_timeout", 80'(0), 80'(1));
    endtask

    initial begin
        int lat, nb;
        logic         o;
        logic [W-1:0] a, b;
        bus.start = 0; bus.op = 0; bus.src_a = 0; bus.src_b = 0;
        reset_n = 0;
        #1;
        chk("rst_status", 80'({bus.busy, bus.done, bus.div_by_zero}), 80'(0));
        chk("rst_hilo", 80'({bus.hi, bus.lo}), 80'(0));
        #11 reset_n = 1;
        @(negedge clk);

        run(0, 7, 6, 0, lat, nb);
        chk("mul7x6_lat", 80'(lat), 80'(33));
        chk("mul7x6_busy", 80'(nb), 80'(32));
        chk("mul7x6_hilo", 80'({bus.hi, bus.lo}), 80'(64'd42));
        chk("model_7x6", 80'(hold_lo), 80'(42));
        @(negedge clk);

        run(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, lat, nb);
        chk("mul_max", 80'({bus.hi, bus.lo}), 80'(64'hFFFFFFFE_00000001));
        chk("model_max", 80'({hold_hi, hold_lo}), 80'(64'hFFFFFFFE_00000001));
        @(negedge clk);

        run(1, 100, 7, 0, lat, nb);
        chk("div100_7", 80'({bus.hi, bus.lo}), 80'({32'd2, 32'd14}));
        chk("div100_7_lat", 80'(lat), 80'(33));
        @(negedge clk);

        run(1, 32'h80000001, 32'h80000000, 0, lat, nb);
        chk("div_pmsb", 80'({bus.hi, bus.lo}), 80'({32'd1, 32'd1}));
        @(negedge clk);

        run(1, 32'h12345678, 0, 0, lat, nb);
        chk("dz_lat", 80'(lat), 80'(1));
        chk("dz_flag", 80'(bus.div_by_zero), 80'(1));
        chk("dz_hilo", 80'({bus.hi, bus.lo}), 80'({32'h12345678, 32'hFFFFFFFF}));
        chk("dz_busy", 80'(nb), 80'(0));
        @(negedge clk);

        run(0, 1000, 3000, 5, lat, nb);
        chk("poke_ignored", 80'({bus.hi, bus.lo}), 80'(64'd3000000));
        chk("poke_lat", 80'(lat), 80'(33));
        @(negedge clk);

        run(1, 1000, 7, 0, lat, nb);
        chk("b2b_first", 80'({bus.hi, bus.lo}), 80'({32'd6, 32'd142}));
        run(0, 12, 11, 0, lat, nb);
        chk("b2b_second", 80'({bus.hi, bus.lo}), 80'(64'd132));
        chk("b2b_lat", 80'(lat), 80'(33));
        @(negedge clk);

        bus.op = 0; bus.src_a = 5; bus.src_b = 9; bus.start = 1;
        @(posedge clk);
        #1 bus.start = 0;
        repeat (10) @(posedge clk);
        #2 reset_n = 0;
        #1;
        chk("midrst_status", 80'({bus.busy, bus.done, bus.div_by_zero}), 80'(0));
        chk("midrst_hilo", 80'({bus.hi, bus.lo}), 80'(0));
        chk("midrst_alu", 80'({alu_cmd, alu_a, alu_b}), 80'(0));
        repeat (2) @(posedge clk);
        #2 reset_n = 1;
        repeat (40) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            o = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 0;
                1:       b = $urandom_range(1, 15);
                2:       b = a;
                default: b = $urandom;
            endcase
            run(o, a, b, 0, lat, nb);
            chk("rnd_lat", 80'(lat), 80'((o && b == 0) ? 1 : 33));
            if ($urandom_range(0, 1) == 1)
                repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end
endmodule
